dsc_op_sequencer: RTL and testbench

Hardware initiator for the DSC `core`: accepts operand sets over a valid/ready stream, sequences the core's reset/enable protocol, and enforces an optional per-operation cycle budget (early termination for accuracy/latency trade-off). Captures the core result, cycle count and a truncation flag into a valid/ready result stream. Keeps running statistics for average-latency and truncation-rate reporting. Sits between the host/operand source and `core`, replacing bench-driven sequencing in system builds.

---
 rtl/dsc_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_dsc_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_op_sequencer.sv
// Operation sequencer for the DSC core: accepts operand sets, drives the core
// reset/enable protocol, enforces an optional cycle budget and reports results/statistics.
module dsc_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned WXIP1      = 2 * DATA_WIDTH + 1
) (
    input  logic                             gclk,
    input  logic                             rst_n,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_data,
    input  logic [WXIP1-1:0]                 op_budget,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic                             core_op_finished,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] res_data,
    output logic [WXIP1-1:0]                 res_cycles,
    output logic                             res_truncated,
    output logic [31:0]                      stat_ops,
    output logic [31:0]                      stat_trunc,
    output logic [47:0]                      stat_cycle_acc
);

    localparam int unsigned DW     = NUM_INPUTS * DATA_WIDTH;
    localparam int unsigned STAT_W = 32;
    localparam int unsigned ACC_W  = 48;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_exit;
    logic               w_trunc;
    logic               w_bud_hit;
    logic               w_ovf;
    logic [ACC_W:0]     w_acc_sum;

    logic               r_op_ready;
    logic               r_core_rst;
    logic               r_core_en;
    logic [DW-1:0]      r_core_data_in;
    logic [WXIP1-1:0]   r_budget;
    logic [WXIP1-1:0]   r_cnt;
    logic               r_res_valid;
    logic [DW-1:0]      r_res_data;
    logic [WXIP1-1:0]   r_res_cycles;
    logic               r_res_truncated;
    logic [STAT_W-1:0]  r_stat_ops;
    logic [STAT_W-1:0]  r_stat_trunc;
    logic [ACC_W-1:0]   r_stat_cycle_acc;

    assign w_bud_hit = (r_budget != '0) && (r_cnt == r_budget);
    assign w_ovf     = (r_cnt == '1);
    assign w_acc_sum = {1'b0, r_stat_cycle_acc} + (ACC_W + 1)'(r_cnt);

    // State register
    always_ff @(posedge gclk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; finish takes priority over a coincident budget hit
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exit      = 1'b0;
        w_trunc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_op_finished || w_bud_hit || w_ovf) begin
                    w_exit      = 1'b1;
                    w_trunc     = !core_op_finished;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered control outputs, operand latch, RUN counter, result capture, statistics
    always_ff @(posedge gclk) begin
        if (!rst_n) begin
            r_op_ready       <= 1'b1;
            r_core_rst       <= 1'b1;
            r_core_en        <= 1'b0;
            r_core_data_in   <= '0;
            r_budget         <= '0;
            r_cnt            <= '0;
            r_res_valid      <= 1'b0;
            r_res_data       <= '0;
            r_res_cycles     <= '0;
            r_res_truncated  <= 1'b0;
            r_stat_ops       <= '0;
            r_stat_trunc     <= '0;
            r_stat_cycle_acc <= '0;
        end else begin
            r_op_ready  <= (w_state_nxt == S_IDLE);
            r_core_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
            r_core_en   <= (w_state_nxt == S_RUN);
            r_res_valid <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_core_data_in <= op_data;
                r_budget       <= op_budget;
                r_cnt          <= '0;
            end

            // Counter reads 1 during the first RUN cycle
            if (r_state == S_LOAD) begin
                r_cnt <= WXIP1'(1);
            end else if ((r_state == S_RUN) && !w_exit) begin
                r_cnt <= r_cnt + WXIP1'(1);
            end

            if (w_exit) begin
                r_res_data      <= core_data_out;
                r_res_cycles    <= r_cnt;
                r_res_truncated <= w_trunc;
                if (r_stat_ops != '1) begin
                    r_stat_ops <= r_stat_ops + STAT_W'(1);
                end
                if (w_trunc && (r_stat_trunc != '1)) begin
                    r_stat_trunc <= r_stat_trunc + STAT_W'(1);
                end
                r_stat_cycle_acc <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
            end
        end
    end

    assign op_ready       = r_op_ready;
    assign core_rst       = r_core_rst;
    assign core_en        = r_core_en;
    assign core_data_in   = r_core_data_in;
    assign res_valid      = r_res_valid;
    assign res_data       = r_res_data;
    assign res_cycles     = r_res_cycles;
    assign res_truncated  = r_res_truncated;
    assign stat_ops       = r_stat_ops;
    assign stat_trunc     = r_stat_trunc;
    assign stat_cycle_acc = r_stat_cycle_acc;

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Directed bench for dsc_op_sequencer: a latency-programmable core model on the
// default instance, plus a narrow instance whose core never finishes.
module tb_dsc_op_sequencer;

    logic        gclk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_data;
    logic [16:0] op_budget;
    logic        core_rst;
    logic        core_en;
    logic [15:0] core_data_in;
    logic        core_op_finished;
    logic [15:0] core_data_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [16:0] res_cycles;
    logic        res_truncated;
    logic [31:0] stat_ops;
    logic [31:0] stat_trunc;
    logic [47:0] stat_cycle_acc;

    logic        op_valid2;
    logic        op_ready2;
    logic [3:0]  op_data2;
    logic [4:0]  op_budget2;
    logic        core_rst2;
    logic        core_en2;
    logic [3:0]  core_data_in2;
    logic        res_valid2;
    logic        res_ready2;
    logic [3:0]  res_data2;
    logic [4:0]  res_cycles2;
    logic        res_truncated2;
    logic [31:0] stat_ops2;
    logic [31:0] stat_trunc2;
    logic [47:0] stat_cycle_acc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 gclk = ~gclk;

    dsc_op_sequencer dut (
        .gclk(gclk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_budget(op_budget),
        .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
        .core_op_finished(core_op_finished), .core_data_out(core_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_truncated(res_truncated),
        .stat_ops(stat_ops), .stat_trunc(stat_trunc), .stat_cycle_acc(stat_cycle_acc)
    );

    dsc_op_sequencer #(.DATA_WIDTH(2)) dut2 (
        .gclk(gclk), .rst_n(rst_n),
        .op_valid(op_valid2), .op_ready(op_ready2), .op_data(op_data2), .op_budget(op_budget2),
        .core_rst(core_rst2), .core_en(core_en2), .core_data_in(core_data_in2),
        .core_op_finished(1'b0), .core_data_out(4'hA),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
        .res_cycles(res_cycles2), .res_truncated(res_truncated2),
        .stat_ops(stat_ops2), .stat_trunc(stat_trunc2), .stat_cycle_acc(stat_cycle_acc2)
    );

    // Core model: finishes on its model_lat-th enabled cycle (0 = never);
    // output byte0 = in0 + k, byte1 = 2*in1 + k, where k = enabled cycles already elapsed
    int model_lat = 0;
    int m_cnt = 0;
    always @(posedge gclk) begin
        if (core_rst === 1'b1) m_cnt <= 0;
        else if (core_en === 1'b1) m_cnt <= m_cnt + 1;
    end
    always_comb begin
        core_op_finished = (core_en === 1'b1) && (model_lat != 0) && (m_cnt == model_lat - 1);
        core_data_out[7:0]  = 8'(core_data_in[7:0] + 8'(m_cnt));
        core_data_out[15:8] = 8'(core_data_in[15:8] * 2 + 8'(m_cnt));
    end

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation on dut; optionally stalls res_ready while offering a new op
    task automatic do_op(input logic [15:0] d, input logic [16:0] b, input int lat, input int stall,
                         output int en_cnt, output bit load_ok, output bit got, output bit stable,
                         output logic [15:0] r_d, output logic [16:0] r_c, output logic r_t);
        model_lat = lat;
        op_data   = d;
        op_budget = b;
        op_valid  = 1'b1;
        tick();
        op_valid  = 1'b0;
        op_data   = '0;
        op_budget = '0;
        load_ok = (core_rst === 1'b0) && (core_en === 1'b0) && (core_data_in === d) && (op_ready === 1'b0);
        en_cnt = 0;
        got    = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (res_valid === 1'b1) got = 1'b1;
            else if (core_en === 1'b1) en_cnt++;
        end
        r_d = res_data;
        r_c = res_cycles;
        r_t = res_truncated;
        if (got && stall > 0) begin
            op_valid  = 1'b1;
            op_data   = 16'hFFFF;
            op_budget = 17'd2;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (res_valid !== 1'b1 || res_data !== r_d || res_cycles !== r_c ||
                    res_truncated !== r_t || op_ready !== 1'b0 || core_en !== 1'b0)
                    stable = 1'b0;
            end
            op_valid  = 1'b0;
            op_data   = '0;
            op_budget = '0;
        end
        if (got) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    int               en_cnt;
    bit               load_ok;
    bit               got;
    bit               stable;
    logic [15:0]      r_d;
    logic [16:0]      r_c;
    logic             r_t;
    int               exp_acc;
    int               cyc_bad;
    bit               got2;

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_data = '0; op_budget = '0; res_ready = 1'b0;
        op_valid2 = 1'b0; op_data2 = '0; op_budget2 = '0; res_ready2 = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_op_ready", op_ready, 1);
        check("rst_core_rst", core_rst, 1);
        check("rst_core_en", core_en, 0);
        check("rst_core_data_in", core_data_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_cycles", res_cycles, 0);
        check("rst_res_trunc", res_truncated, 0);
        check("rst_stat_ops", stat_ops, 0);
        check("rst_stat_trunc", stat_trunc, 0);
        check("rst_stat_acc", stat_cycle_acc, 0);
        rst_n = 1'b1;
        tick();
        check("idle_op_ready", op_ready, 1);

        // Operands {3,7}, latency 5, unlimited budget
        do_op(16'h0703, 17'd0, 5, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t1_got", got, 1);
        check("t1_load", load_ok, 1);
        check("t1_en_cycles", en_cnt, 5);
        check("t1_cycles", r_c, 5);
        check("t1_trunc", r_t, 0);
        check("t1_data", r_d, 16'h1207);
        check("t1_stat_ops", stat_ops, 1);
        check("t1_stat_acc", stat_cycle_acc, 5);
        check("t1_idle", op_ready, 1);

        // Budget 3 truncates before the finish at 5
        do_op(16'h0703, 17'd3, 5, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t2_got", got, 1);
        check("t2_cycles", r_c, 3);
        check("t2_trunc", r_t, 1);
        check("t2_data", r_d, 16'h1005);
        check("t2_stat_trunc", stat_trunc, 1);
        check("t2_stat_ops", stat_ops, 2);
        check("t2_stat_acc", stat_cycle_acc, 8);

        // Finish and budget coincide: finish wins
        do_op(16'h0703, 17'd4, 4, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t3_cycles", r_c, 4);
        check("t3_trunc", r_t, 0);
        check("t3_data", r_d, 16'h1106);
        check("t3_stat_trunc", stat_trunc, 1);

        // Budget 1: one RUN cycle
        do_op(16'h0703, 17'd1, 5, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t4_en_cycles", en_cnt, 1);
        check("t4_cycles", r_c, 1);
        check("t4_trunc", r_t, 1);
        check("t4_data", r_d, 16'h0E03);
        check("t4_stat_acc", stat_cycle_acc, 13);

        // Result backpressure for 10 cycles with a competing op offered
        do_op(16'h0201, 17'd0, 2, 10, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t5_stable", stable, 1);
        check("t5_cycles", r_c, 2);
        check("t5_data", r_d, 16'h0502);
        check("t5_stat_ops", stat_ops, 5);
        check("t5_idle", op_ready, 1);
        do_op(16'h0703, 17'd0, 5, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("t6_got", got, 1);
        check("t6_data", r_d, 16'h1207);
        check("t6_stat_ops", stat_ops, 6);
        check("t6_stat_acc", stat_cycle_acc, 20);

        // Reset during RUN cycle 2 aborts the op
        model_lat = 5; op_data = 16'h0703; op_budget = '0; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        check("ab_in_run", core_en, 1);
        rst_n = 1'b0;
        tick();
        check("ab_core_rst", core_rst, 1);
        check("ab_core_en", core_en, 0);
        check("ab_res_valid", res_valid, 0);
        check("ab_op_ready", op_ready, 1);
        check("ab_stat_ops", stat_ops, 0);
        check("ab_stat_acc", stat_cycle_acc, 0);
        rst_n = 1'b1;
        tick();
        do_op(16'h0703, 17'd0, 3, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
        check("ab_next_got", got, 1);
        check("ab_next_cycles", r_c, 3);
        check("ab_next_data", r_d, 16'h1005);
        check("ab_next_stat_ops", stat_ops, 1);

        // 100 back-to-back ops, latency 1..10
        cyc_bad = 0;
        exp_acc = 3;
        for (int i = 0; i < 100; i++) begin
            do_op(16'(i), 17'd0, (i % 10) + 1, 0, en_cnt, load_ok, got, stable, r_d, r_c, r_t);
            exp_acc += (i % 10) + 1;
            if (!got || r_c !== 17'((i % 10) + 1) || r_t !== 1'b0) cyc_bad++;
        end
        check("b2b_bad_ops", cyc_bad, 0);
        check("b2b_stat_ops", stat_ops, 101);
        check("b2b_stat_acc", stat_cycle_acc, 553);
        check("b2b_stat_acc_model", stat_cycle_acc, 48'(exp_acc));
        check("b2b_stat_trunc", stat_trunc, 0);

        // Narrow instance: core never finishes, overflow guard stops at 31
        check("n_idle", op_ready2, 1);
        op_data2 = 4'h5; op_budget2 = '0; op_valid2 = 1'b1;
        tick();
        op_valid2 = 1'b0;
        check("n_load_data", core_data_in2, 4'h5);
        got2 = 1'b0;
        for (int i = 0; i < 100 && !got2; i++) begin
            tick();
            if (res_valid2 === 1'b1) got2 = 1'b1;
        end
        check("n_got", got2, 1);
        check("n_cycles", res_cycles2, 31);
        check("n_trunc", res_truncated2, 1);
        check("n_data", res_data2, 4'hA);
        check("n_core_rst", core_rst2, 1);
        check("n_stat_trunc", stat_trunc2, 1);
        check("n_stat_acc", stat_cycle_acc2, 31);
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
        check("n_back_idle", op_ready2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
